// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock time-setting logic: FSM state type,
// field moduli and the (non-leap) month-length table.
package clock_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        MONTH,
        DATE,
        DAY,
        HRS,
        MIN,
        PULSE,
        DONE,
        ERR
    } state_t;

    localparam int MIN_N   = 60;
    localparam int HRS_N   = 24;
    localparam int DAY_N   = 7;
    localparam int DATE_N  = 31;
    localparam int MONTH_N = 12;

    // Zero-based month index; out-of-range months report a length of 0.
    function automatic logic [4:0] month_days(input logic [6:0] m);
        logic [4:0] len;
        case (m)
            7'd0:    len = 5'd31;
            7'd1:    len = 5'd28;
            7'd2:    len = 5'd31;
            7'd3:    len = 5'd30;
            7'd4:    len = 5'd31;
            7'd5:    len = 5'd30;
            7'd6:    len = 5'd31;
            7'd7:    len = 5'd31;
            7'd8:    len = 5'd30;
            7'd9:    len = 5'd31;
            7'd10:   len = 5'd30;
            7'd11:   len = 5'd31;
            default: len = 5'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/month_len.sv
// Combinational month-length lookup, shared by target validation and the
// date counter's wrap point.
module month_len
    import clock_pkg::*;
(
    input  logic [6:0] month,
    output logic [4:0] len
);

    assign len = month_days(month);

endmodule

// File: rtl/time_set_driver.sv
// Automatic time-setting initiator: steps the clock's manual set strobes until
// every live field equals the latched target. Optional TSET_TIMEOUT_EN adds a stuck-counter timeout.
module time_set_driver
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] tgt_min,
    input  logic [6:0] tgt_hrs,
    input  logic [6:0] tgt_day,
    input  logic [6:0] tgt_date,
    input  logic [6:0] tgt_month,
    input  logic [6:0] cur_min,
    input  logic [6:0] cur_hrs,
    input  logic [6:0] cur_day,
    input  logic [6:0] cur_date,
    input  logic [6:0] cur_month,
    output logic       Timeset,
    output logic       Minadv,
    output logic       Hrsadv,
    output logic       Dayadv,
    output logic       Dateadv,
    output logic       Monthadv,
    output logic       busy,
    output logic       done,
    output logic       err,
    output state_t     dbg_state
);

    // Handshake: start is sampled only in IDLE; busy rises the cycle after
    // acceptance and stays high through the DONE/ERR cycle; done and err are
    // single-cycle pulses, exactly one of them per accepted start.

    state_t     state;
    state_t     ret_state;
    logic [6:0] tgt_min_q, tgt_hrs_q, tgt_day_q, tgt_date_q, tgt_month_q;
    logic [4:0] tgt_month_len;
    logic       tgt_invalid;
    logic [6:0] cur_sel, tgt_sel;
    state_t     next_field;

    assign dbg_state = state;

    month_len u_month_len (
        .month (tgt_month_q),
        .len   (tgt_month_len)
    );

    assign tgt_invalid = (tgt_min_q   >= 7'(MIN_N))   ||
                         (tgt_hrs_q   >= 7'(HRS_N))   ||
                         (tgt_day_q   >= 7'(DAY_N))   ||
                         (tgt_month_q >= 7'(MONTH_N)) ||
                         (tgt_date_q  >= {2'b00, tgt_month_len});

`ifdef TSET_TIMEOUT_EN
    logic [5:0] steps;
    logic [5:0] mod_sel;
`endif

    // Field mux: the live/target pair and successor for the current field state.
    always_comb begin
        cur_sel    = cur_min;
        tgt_sel    = tgt_min_q;
        next_field = DONE;
`ifdef TSET_TIMEOUT_EN
        mod_sel    = 6'(MIN_N);
`endif
        case (state)
            MONTH: begin
                cur_sel    = cur_month;
                tgt_sel    = tgt_month_q;
                next_field = DATE;
`ifdef TSET_TIMEOUT_EN
                mod_sel    = 6'(MONTH_N);
`endif
            end
            DATE: begin
                cur_sel    = cur_date;
                tgt_sel    = tgt_date_q;
                next_field = DAY;
`ifdef TSET_TIMEOUT_EN
                mod_sel    = 6'(DATE_N);
`endif
            end
            DAY: begin
                cur_sel    = cur_day;
                tgt_sel    = tgt_day_q;
                next_field = HRS;
`ifdef TSET_TIMEOUT_EN
                mod_sel    = 6'(DAY_N);
`endif
            end
            HRS: begin
                cur_sel    = cur_hrs;
                tgt_sel    = tgt_hrs_q;
                next_field = MIN;
`ifdef TSET_TIMEOUT_EN
                mod_sel    = 6'(HRS_N);
`endif
            end
            default: ;
        endcase
    end

    // Outputs are registered from the next state, so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ret_state   <= IDLE;
            tgt_min_q   <= '0;
            tgt_hrs_q   <= '0;
            tgt_day_q   <= '0;
            tgt_date_q  <= '0;
            tgt_month_q <= '0;
            Timeset     <= 1'b0;
            Minadv      <= 1'b0;
            Hrsadv      <= 1'b0;
            Dayadv      <= 1'b0;
            Dateadv     <= 1'b0;
            Monthadv    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef TSET_TIMEOUT_EN
            steps       <= '0;
`endif
        end else begin
            Minadv   <= 1'b0;
            Hrsadv   <= 1'b0;
            Dayadv   <= 1'b0;
            Dateadv  <= 1'b0;
            Monthadv <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt_min_q   <= tgt_min;
                        tgt_hrs_q   <= tgt_hrs;
                        tgt_day_q   <= tgt_day;
                        tgt_date_q  <= tgt_date;
                        tgt_month_q <= tgt_month;
                        state       <= CHECK;
                        Timeset     <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                CHECK: begin
                    if (tgt_invalid) begin
                        state   <= ERR;
                        Timeset <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        state <= MONTH;
`ifdef TSET_TIMEOUT_EN
                        steps <= '0;
`endif
                    end
                end
                MONTH, DATE, DAY, HRS, MIN: begin
                    if (cur_sel == tgt_sel) begin
                        state <= next_field;
`ifdef TSET_TIMEOUT_EN
                        steps <= '0;
`endif
                        if (next_field == DONE) begin
                            Timeset <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
`ifdef TSET_TIMEOUT_EN
                    else if (steps >= mod_sel) begin
                        state   <= ERR;
                        Timeset <= 1'b0;
                        err     <= 1'b1;
                    end
`endif
                    else begin
                        state     <= PULSE;
                        ret_state <= state;
`ifdef TSET_TIMEOUT_EN
                        steps     <= steps + 6'd1;
`endif
                        Monthadv  <= (state == MONTH);
                        Dateadv   <= (state == DATE);
                        Dayadv    <= (state == DAY);
                        Hrsadv    <= (state == HRS);
                        Minadv    <= (state == MIN);
                    end
                end
                PULSE: state <= ret_state;
                DONE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    Timeset <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_driver.sv
// Self-checking bench for time_set_driver: behavioural clock counters plus a
// modular-arithmetic reference for strobe sequence and latency.
module tb_time_set_driver;
    import clock_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] tgt_min = '0, tgt_hrs = '0, tgt_day = '0, tgt_date = '0, tgt_month = '0;
    logic [6:0] cur_min = '0, cur_hrs = '0, cur_day = '0, cur_date = '0, cur_month = '0;
    logic       Timeset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv, busy, done, err;
    state_t     dbg_state;

    // Counter-model controls
    logic       load = 1'b0;
    logic       hold_hrs = 1'b0;
    logic [6:0] ld_min = '0, ld_hrs = '0, ld_day = '0, ld_date = '0, ld_month = '0;

    // Scoreboard / observation
    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int done_cyc, err_cyc, ts_cnt, ts_last, busy_cnt, multi;
    bit timed_out;
    logic busy_after;
    state_t state_after;

    time_set_driver dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tgt_min   (tgt_min),
        .tgt_hrs   (tgt_hrs),
        .tgt_day   (tgt_day),
        .tgt_date  (tgt_date),
        .tgt_month (tgt_month),
        .cur_min   (cur_min),
        .cur_hrs   (cur_hrs),
        .cur_day   (cur_day),
        .cur_date  (cur_date),
        .cur_month (cur_month),
        .Timeset   (Timeset),
        .Minadv    (Minadv),
        .Hrsadv    (Hrsadv),
        .Dayadv    (Dayadv),
        .Dateadv   (Dateadv),
        .Monthadv  (Monthadv),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mdays(input int m);
        case (m)
            1:          return 28;
            3, 5, 8, 10: return 30;
            0, 2, 4, 6, 7, 9, 11: return 31;
            default:    return 0;
        endcase
    endfunction

    // Behavioural clock counters driven by the strobes.
    always @(posedge clk) begin
        if (load) begin
            cur_min   <= ld_min;
            cur_hrs   <= ld_hrs;
            cur_day   <= ld_day;
            cur_date  <= ld_date;
            cur_month <= ld_month;
        end else begin
            if (Minadv)              cur_min   <= 7'((int'(cur_min) + 1) % 60);
            if (Hrsadv && !hold_hrs) cur_hrs   <= 7'((int'(cur_hrs) + 1) % 24);
            if (Dayadv)              cur_day   <= 7'((int'(cur_day) + 1) % 7);
            if (Dateadv)             cur_date  <= 7'((int'(cur_date) + 1) % mdays(int'(cur_month)));
            if (Monthadv)            cur_month <= 7'((int'(cur_month) + 1) % 12);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_cur(input int m, input int h, input int dy, input int dt, input int mo);
        @(posedge clk); #1;
        ld_min = 7'(m); ld_hrs = 7'(h); ld_day = 7'(dy); ld_date = 7'(dt); ld_month = 7'(mo);
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Issues one start and records what the DUT does, cycle by cycle after start.
    task automatic run_case(input int m, input int h, input int dy, input int dt, input int mo,
                            input int limit, input int release_at);
        obs_q.delete();
        done_cyc = 0; err_cyc = 0; ts_cnt = 0; ts_last = 0; busy_cnt = 0; multi = 0;
        timed_out = 1'b0;
        @(posedge clk); #1;
        tgt_min = 7'(m); tgt_hrs = 7'(h); tgt_day = 7'(dy); tgt_date = 7'(dt); tgt_month = 7'(mo);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (release_at != 0 && c == release_at) hold_hrs = 1'b0;
            if (int'(Monthadv) + int'(Dateadv) + int'(Dayadv) + int'(Hrsadv) + int'(Minadv) > 1) multi++;
            if (Monthadv) obs_q.push_back(3'd0);
            if (Dateadv)  obs_q.push_back(3'd1);
            if (Dayadv)   obs_q.push_back(3'd2);
            if (Hrsadv)   obs_q.push_back(3'd3);
            if (Minadv)   obs_q.push_back(3'd4);
            if (Timeset) begin ts_cnt++; ts_last = c; end
            if (busy) busy_cnt++;
            if (done) begin done_cyc = c; break; end
            if (err)  begin err_cyc = c;  break; end
            if (c == limit) timed_out = 1'b1;
        end
        @(negedge clk);
        busy_after  = busy;
        state_after = dbg_state;
    endtask

    // Reference: strobe sequence from field-wise modular distance.
    task automatic build_expect(input int cm, input int ch, input int cdy, input int cdt, input int cmo,
                                input int tm, input int th, input int tdy, input int tdt, input int tmo,
                                output bit valid, output int total);
        int n[5];
        int len;
        exp_q.delete();
        total = 0;
        len = mdays(tmo);
        valid = (tm < 60) && (th < 24) && (tdy < 7) && (tmo < 12) && (tdt < len);
        if (!valid) return;
        n[0] = (tmo - cmo + 12) % 12;
        n[1] = (tdt - cdt + len) % len;
        n[2] = (tdy - cdy + 7) % 7;
        n[3] = (th - ch + 24) % 24;
        n[4] = (tm - cm + 60) % 60;
        for (int f = 0; f < 5; f++)
            for (int k = 0; k < n[f]; k++) begin
                exp_q.push_back(3'(f));
                total++;
            end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({Timeset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv, busy, done, err} !== 9'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected 0", {Timeset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv, busy, done, err});
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        rst = 1'b0;
        load_cur(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        tgt_min = 7'd30; tgt_hrs = '0; tgt_day = '0; tgt_date = '0; tgt_month = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (Timeset !== 1'b1) begin
            n_errors++;
            $display("FAIL midop_timeset: got %b expected 1", Timeset);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({Timeset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv, busy, done, err} !== 9'b0 || dbg_state !== IDLE) begin
            n_errors++;
            $display("FAIL midop_reset: outputs %b state %0d expected 0 / IDLE",
                     {Timeset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv, busy, done, err}, dbg_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        load_cur(0, 0, 0, 0, 0);
        run_case(2, 0, 0, 0, 0, 100, 0);
        n_checks++;
        if (done_cyc !== 11) begin
            n_errors++;
            $display("FAIL after_reset_done: got cycle %0d expected 11", done_cyc);
        end
    endtask

    task automatic test_minutes_only();
        load_cur(0, 0, 0, 0, 0);
        run_case(3, 0, 0, 0, 0, 100, 0);
        n_checks++;
        if (done_cyc !== 13) begin
            n_errors++;
            $display("FAIL min_done_cycle: got %0d expected 13", done_cyc);
        end
        n_checks++;
        if (obs_q.size() !== 3 || obs_q[0] !== 3'd4 || obs_q[1] !== 3'd4 || obs_q[2] !== 3'd4) begin
            n_errors++;
            $display("FAIL min_strobes: got %0d strobes expected 3 Minadv", obs_q.size());
        end
        n_checks++;
        if (ts_cnt !== 12 || ts_last !== 12) begin
            n_errors++;
            $display("FAIL min_timeset: got %0d cycles ending %0d expected 12 ending 12", ts_cnt, ts_last);
        end
        n_checks++;
        if (busy_cnt !== 13 || busy_after !== 1'b0 || state_after !== IDLE) begin
            n_errors++;
            $display("FAIL min_busy: got %0d cycles, after %b state %0d expected 13, 0, IDLE", busy_cnt, busy_after, state_after);
        end
    endtask

    task automatic test_wrap();
        load_cur(59, 0, 0, 0, 0);
        run_case(2, 0, 0, 0, 0, 100, 0);
        n_checks++;
        if (obs_q.size() !== 3 || done_cyc !== 13) begin
            n_errors++;
            $display("FAIL wrap_strobes: got %0d strobes done %0d expected 3 / 13", obs_q.size(), done_cyc);
        end
        n_checks++;
        if (cur_min !== 7'd2) begin
            n_errors++;
            $display("FAIL wrap_final_min: got %0d expected 2", cur_min);
        end
    endtask

    task automatic test_order();
        bit valid;
        int total, bad;
        load_cur(0, 0, 0, 0, 0);
        build_expect(0, 0, 0, 0, 0, 59, 23, 3, 27, 1, valid, total);
        run_case(59, 23, 3, 27, 1, 400, 0);
        n_checks++;
        if (done_cyc !== 233) begin
            n_errors++;
            $display("FAIL order_done_cycle: got %0d expected 233", done_cyc);
        end
        bad = 0;
        if (obs_q.size() != exp_q.size()) bad = 1000;
        else for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL order_sequence: got %0d strobes with %0d misordered expected %0d in order", obs_q.size(), bad, total);
        end
        n_checks++;
        if (multi !== 0) begin
            n_errors++;
            $display("FAIL order_one_hot: got %0d multi-strobe cycles expected 0", multi);
        end
        n_checks++;
        if ({cur_month, cur_date, cur_day, cur_hrs, cur_min} !== {7'd1, 7'd27, 7'd3, 7'd23, 7'd59}) begin
            n_errors++;
            $display("FAIL order_final: got %0d/%0d/%0d/%0d/%0d expected 1/27/3/23/59",
                     cur_month, cur_date, cur_day, cur_hrs, cur_min);
        end
    endtask

    task automatic test_invalid();
        load_cur(0, 0, 0, 0, 0);
        run_case(0, 0, 0, 28, 1, 50, 0);
        n_checks++;
        if (err_cyc !== 2 || done_cyc !== 0) begin
            n_errors++;
            $display("FAIL invalid_err: got err %0d done %0d expected err 2 done 0", err_cyc, done_cyc);
        end
        n_checks++;
        if (obs_q.size() !== 0) begin
            n_errors++;
            $display("FAIL invalid_strobes: got %0d expected 0", obs_q.size());
        end
        n_checks++;
        if (ts_cnt !== 1 || ts_last !== 1) begin
            n_errors++;
            $display("FAIL invalid_timeset: got %0d cycles ending %0d expected 1 ending 1", ts_cnt, ts_last);
        end
    endtask

    task automatic test_random();
        bit valid;
        int total, bad;
        int cm, ch, cdy, cdt, cmo, tm, th, tdy, tdt, tmo;
        for (int it = 0; it < 8; it++) begin
            cm = $urandom_range(0, 59); ch = $urandom_range(0, 23); cdy = $urandom_range(0, 6);
            cdt = $urandom_range(0, 27); cmo = $urandom_range(0, 11);
            tm = $urandom_range(0, 59); th = $urandom_range(0, 23); tdy = $urandom_range(0, 6);
            tmo = $urandom_range(0, 11); tdt = $urandom_range(0, mdays(tmo) - 1);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: tdt = mdays(tmo) + $urandom_range(0, 2);
                    1: tmo = $urandom_range(12, 20);
                    2: tm = $urandom_range(60, 127);
                    default: th = $urandom_range(24, 40);
                endcase
            end
            load_cur(cm, ch, cdy, cdt, cmo);
            build_expect(cm, ch, cdy, cdt, cmo, tm, th, tdy, tdt, tmo, valid, total);
            run_case(tm, th, tdy, tdt, tmo, 400, 0);
            if (valid) begin
                n_checks++;
                if (done_cyc !== 7 + 2 * total) begin
                    n_errors++;
                    $display("FAIL rand_done[%0d]: got cycle %0d expected %0d", it, done_cyc, 7 + 2 * total);
                end
                bad = 0;
                if (obs_q.size() != exp_q.size()) bad = 1000;
                else for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
                n_checks++;
                if (bad != 0 || multi != 0) begin
                    n_errors++;
                    $display("FAIL rand_seq[%0d]: got %0d strobes %0d bad %0d multi expected %0d", it, obs_q.size(), bad, multi, total);
                end
                n_checks++;
                if ({cur_month, cur_date, cur_day, cur_hrs, cur_min} !== {7'(tmo), 7'(tdt), 7'(tdy), 7'(th), 7'(tm)}) begin
                    n_errors++;
                    $display("FAIL rand_final[%0d]: got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d", it,
                             cur_month, cur_date, cur_day, cur_hrs, cur_min, tmo, tdt, tdy, th, tm);
                end
            end else begin
                n_checks++;
                if (err_cyc !== 2 || obs_q.size() !== 0) begin
                    n_errors++;
                    $display("FAIL rand_invalid[%0d]: got err %0d strobes %0d expected err 2 strobes 0", it, err_cyc, obs_q.size());
                end
            end
        end
    endtask

    task automatic test_timeout();
        int hcount;
        load_cur(0, 5, 0, 0, 0);
        hold_hrs = 1'b1;
`ifdef TSET_TIMEOUT_EN
        run_case(0, 6, 0, 0, 0, 200, 0);
        hold_hrs = 1'b0;
        hcount = 0;
        foreach (obs_q[i]) if (obs_q[i] === 3'd3) hcount++;
        n_checks++;
        if (hcount !== 24 || obs_q.size() !== 24) begin
            n_errors++;
            $display("FAIL timeout_strobes: got %0d Hrsadv of %0d expected 24", hcount, obs_q.size());
        end
        n_checks++;
        if (err_cyc !== 54 || done_cyc !== 0 || state_after !== IDLE) begin
            n_errors++;
            $display("FAIL timeout_err: got err %0d done %0d state %0d expected 54 / 0 / IDLE", err_cyc, done_cyc, state_after);
        end
`else
        run_case(0, 6, 0, 0, 0, 200, 60);
        hold_hrs = 1'b0;
        hcount = 0;
        foreach (obs_q[i]) if (obs_q[i] === 3'd3) hcount++;
        n_checks++;
        if (hcount !== 28 || obs_q.size() !== 28) begin
            n_errors++;
            $display("FAIL stuck_strobes: got %0d Hrsadv of %0d expected 28", hcount, obs_q.size());
        end
        n_checks++;
        if (done_cyc !== 63 || err_cyc !== 0) begin
            n_errors++;
            $display("FAIL stuck_done: got done %0d err %0d expected 63 / 0", done_cyc, err_cyc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_minutes_only();
        test_wrap();
        test_order();
        test_invalid();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
